// File: rtl/hs_pause_pkg.sv
// Shared types and default constants for the pause sequencer slice.
package hs_pause_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } hs_state_e;

  localparam logic [31:0] DIM_CYCLES_48M = 32'h1C9C3800;
  localparam int unsigned HS_SETTLE_DEF  = 16;

endpackage

// File: rtl/dim_timer.sv
// Saturating pause-duration counter; the dim output only changes during vblank.
module dim_timer
  import hs_pause_pkg::*;
#(
  parameter logic [31:0] LIMIT = DIM_CYCLES_48M
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run,
  input  logic vblank,
  output logic dim
);

  logic [31:0] dim_cnt_q, dim_cnt_d;
  logic        dim_q, dim_d;
  logic        dim_req;

  always_comb begin
    dim_req   = (dim_cnt_q >= LIMIT);
    dim_cnt_d = '0;
    if (run) begin
      dim_cnt_d = dim_req ? LIMIT : dim_cnt_q + 32'd1;
    end
    dim_d = vblank ? dim_req : dim_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dim_cnt_q <= '0;
      dim_q     <= 1'b0;
    end else begin
      dim_cnt_q <= dim_cnt_d;
      dim_q     <= dim_d;
    end
  end

  assign dim = dim_q;

endmodule

// File: rtl/hs_pause_ctrl.sv
// Pause sequencer: merges pause sources, grants hiscore RAM access after a
// settle interval of halted CPU, and drives the long-pause video dim.
module hs_pause_ctrl
  import hs_pause_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_48M,
  parameter int unsigned HS_SETTLE  = HS_SETTLE_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic btn_pause,
  input  logic osd_pause,
  input  logic hs_req,
  input  logic vblank,
  output logic pause,
  output logic hs_grant,
  output logic dim_video,
  output logic user_paused
);

  localparam logic [7:0] SETTLE_LAST = 8'(HS_SETTLE - 1);

  hs_state_e  state_q, state_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       btn_q;
  logic       user_paused_q, user_paused_d;
  logic       src;

  always_comb begin
    user_paused_d = user_paused_q ^ (btn_pause & ~btn_q);
    src           = user_paused_q | osd_pause | hs_req;
    state_d       = state_q;
    settle_cnt_d  = '0;

    case (state_q)
      ST_RUN: begin
        if (src) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!src) begin
          state_d = ST_RUN;
        end else if (hs_req) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_GRANT;
          else                             settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_GRANT: begin
        // Only the hiscore request matters here; other sources wait for RELEASE.
        if (!hs_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      settle_cnt_q  <= '0;
      btn_q         <= 1'b0;
      user_paused_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      btn_q         <= btn_pause;
      user_paused_q <= user_paused_d;
    end
  end

  assign pause       = (state_q != ST_RUN);
  assign hs_grant    = (state_q == ST_GRANT);
  assign user_paused = user_paused_q;

  dim_timer #(
    .LIMIT(DIM_CYCLES)
  ) u_dim_timer (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .run    (pause),
    .vblank (vblank),
    .dim    (dim_video)
  );

endmodule
